// File: rtl/seven_seg_scan_if.sv
// Display-side bundle for the 4-digit scanner: BCD digits and mode controls in,
// multiplexed anode/segment/decimal-point drive and frame pulse out.
interface seven_seg_scan_if;
   logic [3:0] disp_Tenths_Seconds;
   logic [3:0] disp_Ones_Seconds;
   logic [3:0] disp_Tens_Seconds;
   logic [3:0] disp_Minutes;
   logic       blank;
   logic       blink;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   modport master (
      output disp_Tenths_Seconds, disp_Ones_Seconds, disp_Tens_Seconds, disp_Minutes,
      output blank, blink,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  disp_Tenths_Seconds, disp_Ones_Seconds, disp_Tens_Seconds, disp_Minutes,
      input  blank, blink,
      output an, seg, dp, frame_tick
   );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshots,
// leading-zero blanking, decimal points, blink and blank modes.
module seven_seg_scan #(
   parameter int SCAN_DIV   = 2500,
   parameter int BLINK_DIV  = 50,
   parameter bit BLANK_LZ   = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   seven_seg_scan_if.slave   bus
);

   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {PHASE_ON, PHASE_OFF} phase_t;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [1:0]         digit;
   logic [BLINK_W-1:0] blink_cnt;
   phase_t             phase;
   logic [3:0]         snap_tenths;
   logic [3:0]         snap_ones;
   logic [3:0]         snap_tens;
   logic [3:0]         snap_min;

   logic               scan_tick;
   logic               frame_edge;
   logic [3:0]         cur_bcd;
   logic               dark;
   logic [6:0]         seg_code;
   logic [3:0]         an_h;
   logic [6:0]         seg_h;
   logic               dp_h;

   assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign frame_edge = scan_tick && (digit == 2'd3);

   // Next output pattern in active-high form, built from the current digit and snapshot
   always_comb begin
      cur_bcd  = 4'd0;
      seg_code = 7'h40;
      an_h     = 4'b0000;
      seg_h    = 7'h00;
      dp_h     = 1'b0;
      case (digit)
         2'd0:    cur_bcd = snap_tenths;
         2'd1:    cur_bcd = snap_ones;
         2'd2:    cur_bcd = snap_tens;
         default: cur_bcd = snap_min;
      endcase
      dark = BLANK_LZ &&
             (((digit == 2'd3) && (snap_min == 4'd0)) ||
              ((digit == 2'd2) && (snap_min == 4'd0) && (snap_tens == 4'd0)));
      case (cur_bcd)
         4'd0:    seg_code = 7'h3F;
         4'd1:    seg_code = 7'h06;
         4'd2:    seg_code = 7'h5B;
         4'd3:    seg_code = 7'h4F;
         4'd4:    seg_code = 7'h66;
         4'd5:    seg_code = 7'h6D;
         4'd6:    seg_code = 7'h7D;
         4'd7:    seg_code = 7'h07;
         4'd8:    seg_code = 7'h7F;
         4'd9:    seg_code = 7'h6F;
         default: seg_code = 7'h40;
      endcase
      // Decimal points sit after the seconds-ones and minutes digits (odd indices)
      if (!bus.blank && !dark) begin
         seg_h = seg_code;
         dp_h  = digit[0];
         if (phase == PHASE_ON) an_h = 4'b0001 << digit;
      end
   end

   // Scan counter, frame snapshot, blink phase and registered output drive
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_cnt       <= '0;
         digit          <= 2'd0;
         blink_cnt      <= '0;
         phase          <= PHASE_ON;
         snap_tenths    <= 4'd0;
         snap_ones      <= 4'd0;
         snap_tens      <= 4'd0;
         snap_min       <= 4'd0;
         bus.frame_tick <= 1'b0;
         bus.an         <= ACTIVE_LOW ? 4'hF : 4'h0;
         bus.seg        <= ACTIVE_LOW ? 7'h7F : 7'h00;
         bus.dp         <= ACTIVE_LOW ? 1'b1 : 1'b0;
      end else begin
         scan_cnt       <= scan_tick ? '0 : scan_cnt + 1'b1;
         bus.frame_tick <= frame_edge;
         if (scan_tick) digit <= digit + 2'd1;
         if (frame_edge) begin
            snap_tenths <= bus.disp_Tenths_Seconds;
            snap_ones   <= bus.disp_Ones_Seconds;
            snap_tens   <= bus.disp_Tens_Seconds;
            snap_min    <= bus.disp_Minutes;
         end
         if (!bus.blink) begin
            blink_cnt <= '0;
            phase     <= PHASE_ON;
         end else if (frame_edge) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
               blink_cnt <= '0;
               phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
         bus.an  <= ACTIVE_LOW ? ~an_h  : an_h;
         bus.seg <= ACTIVE_LOW ? ~seg_h : seg_h;
         bus.dp  <= ACTIVE_LOW ? ~dp_h  : dp_h;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=4, BLINK_DIV=2, active-low outputs;
// expected drive patterns are hand-decoded constants.
module tb_seven_seg_scan;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   seven_seg_scan_if bus ();

   seven_seg_scan #(
      .SCAN_DIV   (4),
      .BLINK_DIV  (2),
      .BLANK_LZ   (1'b1),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample point is 1 time unit after each rising edge
   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sync_frame(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.frame_tick !== 1'b1 && n < 40);
      check(tag, {7'd0, bus.frame_tick}, 8'd1);
   endtask

   task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
      check({tag, ".an"},  {4'd0, bus.an},  {4'd0, an});
      check({tag, ".seg"}, {1'b0, bus.seg}, {1'b0, seg});
      check({tag, ".dp"},  {7'd0, bus.dp},  {7'd0, dp});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      bus.disp_Minutes        = 4'd1;
      bus.disp_Tens_Seconds   = 4'd2;
      bus.disp_Ones_Seconds   = 4'd3;
      bus.disp_Tenths_Seconds = 4'd4;
      bus.blank = 1'b0;
      bus.blink = 1'b0;

      // Reset held for three edges, then released; snapshot is still all zeros
      wait_cycles(3);
      check_out("rst", 4'hF, 7'h7F, 1'b1);
      check("rst.ft", {7'd0, bus.frame_tick}, 8'd0);
      reset = 1'b1;
      wait_cycles(1);
      check_out("zero.d0", 4'hE, 7'h40, 1'b1);
      wait_cycles(4);
      check_out("zero.d1", 4'hD, 7'h40, 1'b0);
      wait_cycles(4);
      check_out("zero.d2dark", 4'hF, 7'h7F, 1'b1);
      wait_cycles(6);
      check("ft.c15", {7'd0, bus.frame_tick}, 8'd0);
      wait_cycles(1);
      check("ft.c16", {7'd0, bus.frame_tick}, 8'd1);

      // Frame holding 1:23.4
      wait_cycles(1);
      check("ft.pulse", {7'd0, bus.frame_tick}, 8'd0);
      check_out("f1.d0", 4'hE, 7'h19, 1'b1);
      wait_cycles(4);
      check_out("f1.d1", 4'hD, 7'h30, 1'b0);
      wait_cycles(4);
      check_out("f1.d2", 4'hB, 7'h24, 1'b1);
      wait_cycles(4);
      check_out("f1.d3", 4'h7, 7'h79, 1'b0);

      // 0:07.5 with leading zeros blanked, and a mid-frame tenths change
      bus.disp_Minutes        = 4'd0;
      bus.disp_Tens_Seconds   = 4'd0;
      bus.disp_Ones_Seconds   = 4'd7;
      bus.disp_Tenths_Seconds = 4'd5;
      sync_frame("f2.sync");
      wait_cycles(1);
      check_out("f2.d0", 4'hE, 7'h12, 1'b1);
      wait_cycles(1);
      bus.disp_Tenths_Seconds = 4'd6;
      wait_cycles(1);
      check_out("f2.hold", 4'hE, 7'h12, 1'b1);
      wait_cycles(2);
      check_out("f2.d1", 4'hD, 7'h78, 1'b0);
      wait_cycles(4);
      check_out("f2.d2dark", 4'hF, 7'h7F, 1'b1);
      wait_cycles(4);
      check_out("f2.d3dark", 4'hF, 7'h7F, 1'b1);
      sync_frame("f3.sync");
      wait_cycles(1);
      check_out("f3.d0", 4'hE, 7'h02, 1'b1);

      // Illegal BCD shows a dash; blank darkens everything while frames continue
      bus.disp_Tenths_Seconds = 4'hC;
      sync_frame("f4.sync");
      wait_cycles(1);
      check_out("f4.dash", 4'hE, 7'h3F, 1'b1);
      bus.blank = 1'b1;
      wait_cycles(1);
      check_out("blank", 4'hF, 7'h7F, 1'b1);
      sync_frame("blank.ft");
      check_out("blank.hold", 4'hF, 7'h7F, 1'b1);
      bus.blank = 1'b0;
      wait_cycles(1);
      check_out("unblank", 4'hE, 7'h3F, 1'b1);

      // Blink: phase toggles every second frame boundary after blink rises
      bus.blink = 1'b1;
      sync_frame("bl.s1");
      wait_cycles(1);
      check("bl.on1", {4'd0, bus.an}, 8'h0E);
      sync_frame("bl.s2");
      wait_cycles(1);
      check("bl.off1", {4'd0, bus.an}, 8'h0F);
      wait_cycles(4);
      check("bl.off1b", {4'd0, bus.an}, 8'h0F);
      sync_frame("bl.s3");
      wait_cycles(1);
      check("bl.off2", {4'd0, bus.an}, 8'h0F);
      sync_frame("bl.s4");
      wait_cycles(1);
      check("bl.on2", {4'd0, bus.an}, 8'h0E);
      sync_frame("bl.s5");
      sync_frame("bl.s6");
      wait_cycles(1);
      check("bl.off3", {4'd0, bus.an}, 8'h0F);
      wait_cycles(3);
      bus.blink = 1'b0;
      wait_cycles(2);
      check_out("bl.drop", 4'hD, 7'h78, 1'b0);

      // Reset mid-scan restarts at digit 0 with a cleared snapshot
      reset = 1'b0;
      wait_cycles(1);
      check_out("rst2", 4'hF, 7'h7F, 1'b1);
      check("rst2.ft", {7'd0, bus.frame_tick}, 8'd0);
      reset = 1'b1;
      wait_cycles(1);
      check_out("rst2.d0", 4'hE, 7'h40, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
